shift_accum: RTL

Accumulator stage directly downstream of the left shifter. Each cycle it is fed a pair of 16-bit shifted operands and adds both into a running sum. After a programmable number of accepted beats it publishes the total and pulses `done`. A start/valid handshake frames each accumulation run.

---
 rtl/shift_accum_if.sv | 33 +++
 rtl/shift_accum.sv | 116 +++++++++++
 2 files changed

// File: rtl/shift_accum_if.sv
//------------------------------------------------------------------------------
// Module      : shift_accum_if
// Description : Handshake/data bundle between the left shifter (master) and
//               the shift_accum accumulator stage (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface shift_accum_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 18
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] shifted_a;
  logic [DATA_W-1:0] shifted_b;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;
  logic              overflow;

  modport master (
    output start, in_valid, shifted_a, shifted_b,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, in_valid, shifted_a, shifted_b,
    output busy, done, result, overflow
  );
endinterface

`default_nettype wire

// File: rtl/shift_accum.sv
//------------------------------------------------------------------------------
// Module      : shift_accum
// Description : Accumulates pairs of zero-extended shifted operands over
//               NUM_BEATS accepted beats, then publishes the sum, a sticky
//               overflow flag and a one-cycle done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_accum #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 18,
  parameter int NUM_BEATS = 4
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  shift_accum_if.slave  bus
);

  // State encoding
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ACCUM = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  // Beat index of the final beat of a run (NUM_BEATS is 1..255)
  localparam logic [7:0] c_LAST_BEAT = 8'(NUM_BEATS - 1);

  // Zero padding that widens an operand to the accumulator width plus carry
  localparam int c_PAD_W = ACC_W + 1 - DATA_W;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf_trk;
  logic             r_busy;
  logic             r_done;
  logic [ACC_W-1:0] r_result;
  logic             r_overflow;

  logic [ACC_W:0]   w_op_a;
  logic [ACC_W:0]   w_op_b;
  logic [ACC_W:0]   w_sum;
  logic             w_beat;

  // Unsigned operands only: widen with zeros, one spare bit holds the carry.
  // acc + a + b < 2^(ACC_W+1) because DATA_W <= ACC_W-1, so one bit suffices.
  assign w_op_a = {{c_PAD_W{1'b0}}, bus.shifted_a};
  assign w_op_b = {{c_PAD_W{1'b0}}, bus.shifted_b};
  assign w_sum  = {1'b0, r_acc} + w_op_a + w_op_b;
  assign w_beat = (r_state == c_ACCUM) && bus.in_valid;

  // Run control and running sum; beats are only accepted in ACCUM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_trk <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // busy stays high for the cycle after DONE (done pulse cycle) and
          // drops here unless a new run starts on this very edge.
          r_busy <= bus.start;
          if (bus.start) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_trk <= 1'b0;
            r_state   <= c_ACCUM;
          end
        end
        c_ACCUM: begin
          if (w_beat) begin
            r_acc     <= w_sum[ACC_W-1:0];
            r_ovf_trk <= r_ovf_trk | w_sum[ACC_W];
            r_cnt     <= r_cnt + 8'd1;
            if (r_cnt == c_LAST_BEAT) begin
              r_state <= c_DONE;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Publish the finished sum and flag once, with a single-cycle done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == c_DONE);
      if (r_state == c_DONE) begin
        r_result   <= r_acc;
        r_overflow <= r_ovf_trk;
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire
